i2c_eeprom_resp: RTL and testbench



---
 rtl/i2c_eeprom_resp.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_eeprom_resp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_resp.sv
`default_nettype none
// ============================================================================
// Module   : i2c_eeprom_resp
// Purpose  : 24C0x-style serial EEPROM responder. Decodes START/STOP and
//            the device-address, word-address, write and read phases from
//            bit-banged SCL/SDA levels. Array storage lives in external SRAM
//            reached through a simple address/data/strobe port.
// Options  : I2C_EEPROM_WP_EN adds a write-protect input `wp`. When wp is 1,
//            written bytes are acknowledged and the address still advances,
//            but no SRAM write is issued.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_eeprom_resp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PAGE_W = 3,
  parameter logic [3:0]  DEV_ID = 4'b1010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
`ifdef I2C_EEPROM_WP_EN
  input  logic              wp,
`endif
  output logic              sda_out,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_di,
  output logic [7:0]        mem_do,
  output logic              mem_we,
  output logic              busy
);

  // Low PAGE_W address bits wrap during page writes; upper bits are held.
  localparam logic [ADDR_W-1:0] C_PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

  typedef enum logic [2:0] {
    C_IDLE       = 3'd0,
    C_DEV_ADDR   = 3'd1,
    C_WORD_ADDR  = 3'd2,
    C_WRITE_DATA = 3'd3,
    C_READ_DATA  = 3'd4
  } state_t;

  // Registered state
  state_t            r_state;
  logic [3:0]        r_bit_cnt;   // SCL rises seen in the current 9-bit slot
  logic [7:0]        r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sda_out;
  logic              r_mem_we;
  logic [7:0]        r_mem_do;
  logic              r_rw;
  logic              r_scl_q;
  logic              r_sda_q;

  // Next-state values
  state_t            w_state_nxt;
  logic [3:0]        w_bit_cnt_nxt;
  logic [7:0]        w_shift_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_sda_out_nxt;
  logic              w_mem_we_nxt;
  logic [7:0]        w_mem_do_nxt;
  logic              w_rw_nxt;

  // Bus condition decode
  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_scl_stable_hi;
  logic              w_start;
  logic              w_stop;
  logic [7:0]        w_shift_in;
  logic [ADDR_W-1:0] w_addr_page_inc;
  logic [ADDR_W-1:0] w_addr_full_inc;
  logic              w_wr_en;

  assign w_scl_rise      = scl_in & ~r_scl_q;
  assign w_scl_fall      = ~scl_in & r_scl_q;
  // START/STOP only count while SCL is high and not moving, so a
  // simultaneous SCL+SDA change is handled as an SCL edge alone.
  assign w_scl_stable_hi = scl_in & r_scl_q;
  assign w_start         = w_scl_stable_hi & r_sda_q & ~sda_in;
  assign w_stop          = w_scl_stable_hi & ~r_sda_q & sda_in;
  assign w_shift_in      = {r_shift[6:0], sda_in};
  assign w_addr_full_inc = r_addr + ADDR_W'(1);
  assign w_addr_page_inc = (r_addr & ~C_PAGE_MASK) | (w_addr_full_inc & C_PAGE_MASK);

`ifdef I2C_EEPROM_WP_EN
  assign w_wr_en = ~wp;
`else
  assign w_wr_en = 1'b1;
`endif

  assign sda_out  = r_sda_out;
  assign mem_addr = r_addr;
  assign mem_do   = r_mem_do;
  assign mem_we   = r_mem_we;
  assign busy     = (r_state != C_IDLE);

  // Register the raw bus levels for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= scl_in;
      r_sda_q <= sda_in;
    end
  end

  // FSM and datapath state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= C_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_addr    <= '0;
      r_sda_out <= 1'b1;
      r_mem_we  <= 1'b0;
      r_mem_do  <= 8'd0;
      r_rw      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_sda_out <= w_sda_out_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_mem_do  <= w_mem_do_nxt;
      r_rw      <= w_rw_nxt;
    end
  end

  // Next-state and output decode; bits sampled on SCL rise, SDA driven on SCL fall
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_addr_nxt    = r_addr;
    w_sda_out_nxt = r_sda_out;
    w_mem_we_nxt  = 1'b0;
    w_mem_do_nxt  = r_mem_do;
    w_rw_nxt      = r_rw;

    if (w_start) begin
      w_state_nxt   = C_DEV_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_out_nxt = 1'b1;
    end else if (w_stop) begin
      w_state_nxt   = C_IDLE;
      w_bit_cnt_nxt = 4'd0;
      w_sda_out_nxt = 1'b1;
    end else begin
      case (r_state)
        C_DEV_ADDR, C_WORD_ADDR, C_WRITE_DATA: begin
          if (w_scl_rise) begin
            if (r_bit_cnt < 4'd8) begin
              w_shift_nxt   = w_shift_in;
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                // Full byte received on this rise
                case (r_state)
                  C_DEV_ADDR: begin
                    if (w_shift_in[7:4] == DEV_ID) begin
                      w_rw_nxt = w_shift_in[0];
                    end else begin
                      w_state_nxt   = C_IDLE;
                      w_bit_cnt_nxt = 4'd0;
                    end
                  end
                  C_WORD_ADDR: begin
                    w_addr_nxt = ADDR_W'(w_shift_in);
                  end
                  C_WRITE_DATA: begin
                    w_mem_we_nxt = w_wr_en;
                    w_mem_do_nxt = w_shift_in;
                  end
                  default: ;
                endcase
              end
            end else if (r_bit_cnt == 4'd8) begin
              // 9th rise: master samples our ACK. Advance the page
              // address only after the strobe has used the old one.
              w_bit_cnt_nxt = 4'd9;
              if (r_state == C_WRITE_DATA) begin
                w_addr_nxt = w_addr_page_inc;
              end
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_out_nxt = 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
              w_sda_out_nxt = 1'b1;
              w_bit_cnt_nxt = 4'd0;
              case (r_state)
                C_DEV_ADDR: begin
                  if (r_rw) begin
                    // Read: first data bit goes out on the fall ending ACK
                    w_state_nxt   = C_READ_DATA;
                    w_sda_out_nxt = mem_di[7];
                    w_shift_nxt   = {mem_di[6:0], 1'b0};
                  end else begin
                    w_state_nxt = C_WORD_ADDR;
                  end
                end
                C_WORD_ADDR: w_state_nxt = C_WRITE_DATA;
                default: ;
              endcase
            end
          end
        end

        C_READ_DATA: begin
          if (w_scl_rise) begin
            if (r_bit_cnt < 4'd8) begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end else if (r_bit_cnt == 4'd8) begin
              if (!sda_in) begin
                w_addr_nxt    = w_addr_full_inc;
                w_bit_cnt_nxt = 4'd9;
              end else begin
                w_state_nxt   = C_IDLE;
                w_bit_cnt_nxt = 4'd0;
                w_sda_out_nxt = 1'b1;
              end
            end
          end else if (w_scl_fall) begin
            if ((r_bit_cnt != 4'd0) && (r_bit_cnt < 4'd8)) begin
              w_sda_out_nxt = r_shift[7];
              w_shift_nxt   = {r_shift[6:0], 1'b0};
            end else if (r_bit_cnt == 4'd8) begin
              // Release for the master's ACK/NACK slot
              w_sda_out_nxt = 1'b1;
            end else if (r_bit_cnt == 4'd9) begin
              w_sda_out_nxt = mem_di[7];
              w_shift_nxt   = {mem_di[6:0], 1'b0};
              w_bit_cnt_nxt = 4'd0;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_eeprom_resp
// Purpose  : Self-checking bench for i2c_eeprom_resp with an SRAM model and
//            a byte-level reference of the EEPROM array and address pointer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_resp;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
`ifdef I2C_EEPROM_WP_EN
  logic       wp = 1'b0;
`endif
  logic       sda_out;
  logic [7:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do;
  logic       mem_we;
  logic       busy;

  always #5 clk = ~clk;

  i2c_eeprom_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
`ifdef I2C_EEPROM_WP_EN
    .wp       (wp),
`endif
    .sda_out  (sda_out),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do),
    .mem_we   (mem_we),
    .busy     (busy)
  );

  // SRAM model (1-clk read latency) with a bench-side preload port
  logic [7:0]  sram [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [7:0]  pre_data = 8'd0;
  logic [15:0] we_log [$];

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (mem_we) begin
      sram[mem_addr] <= mem_do;
      we_log.push_back({mem_addr, mem_do});
    end
    mem_di <= sram[mem_addr];
  end

  // Reference model: array contents and the internal address pointer
  logic [7:0] ref_mem [256];
  int         ref_addr;
  logic [7:0] wdata [8];
  logic [7:0] rdata [8];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int page_inc(input int a);
    return (a / 8) * 8 + ((a % 8) + 1) % 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick(1);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start_c();
    sda_in = 1'b1; tick(HALF);
    scl_in = 1'b1; tick(HALF);
    sda_in = 1'b0; tick(HALF);
    scl_in = 1'b0; tick(2);
  endtask

  task automatic stop_c();
    sda_in = 1'b0; tick(HALF);
    scl_in = 1'b1; tick(HALF);
    sda_in = 1'b1; tick(HALF);
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;    tick(HALF);
    scl_in = 1'b1; tick(HALF);
    scl_in = 1'b0; tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_in = 1'b1; tick(HALF);
    scl_in = 1'b1; tick(HALF / 2);
    ack = sda_in & sda_out;
    tick(HALF / 2);
    scl_in = 1'b0; tick(2);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_in = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(HALF);
      scl_in = 1'b1; tick(HALF / 2);
      b[i] = sda_in & sda_out;
      tick(HALF / 2);
      scl_in = 1'b0; tick(2);
    end
    sda_in = mack; tick(HALF);
    scl_in = 1'b1; tick(HALF);
    scl_in = 1'b0; tick(2);
    sda_in = 1'b1;
  endtask

  // Full write transaction; commit=0 models a protected write
  task automatic do_write(input string tag, input logic [7:0] a, input int n, input logic commit);
    logic        ack;
    logic [15:0] exp_q [$];
    logic [15:0] obs;
    we_log.delete();
    start_c();
    write_byte(8'hA0, ack); check({tag, " dev ack"}, 32'(ack), 32'd0);
    write_byte(a, ack);     check({tag, " word ack"}, 32'(ack), 32'd0);
    ref_addr = int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(wdata[i], ack);
      check($sformatf("%s data%0d ack", tag, i), 32'(ack), 32'd0);
      if (commit) begin
        exp_q.push_back({8'(ref_addr), wdata[i]});
        ref_mem[ref_addr] = wdata[i];
      end
      ref_addr = page_inc(ref_addr);
    end
    stop_c();
    check({tag, " busy after stop"}, 32'(busy), 32'd0);
    check({tag, " we count"}, 32'(we_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < we_log.size()) ? we_log[i] : 16'hxxxx;
      check($sformatf("%s we%0d addr/data", tag, i), 32'(obs), 32'(exp_q[i]));
    end
  endtask

  // Read transaction: random (with word address) or current-address
  task automatic do_read(input string tag, input logic random_rd, input logic [7:0] a, input int n);
    logic ack;
    start_c();
    if (random_rd) begin
      write_byte(8'hA0, ack); check({tag, " dev ack"}, 32'(ack), 32'd0);
      write_byte(a, ack);     check({tag, " word ack"}, 32'(ack), 32'd0);
      ref_addr = int'(a);
      start_c();
    end
    write_byte(8'hA1, ack); check({tag, " rd dev ack"}, 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1), rdata[i]);
      check($sformatf("%s byte%0d", tag, i), 32'(rdata[i]), 32'(ref_mem[ref_addr]));
      if (i != n - 1) ref_addr = (ref_addr + 1) % 256;
    end
    check({tag, " busy after nack"}, 32'(busy), 32'd0);
    check({tag, " sda released"}, 32'(sda_out), 32'd1);
    stop_c();
  endtask

  // Directed sequence followed by randomized traffic
  initial begin
    logic       ack;
    logic [7:0] v;
    int         n;
    logic [7:0] a;

    tick(4);
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      preload(8'(i), v);
    end
    check("reset sda_out", 32'(sda_out), 32'd1);
    check("reset busy",    32'(busy),    32'd0);
    check("reset mem_we",  32'(mem_we),  32'd0);
    check("reset mem_do",  32'(mem_do),  32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    ref_addr = 0;
    tick(4);

    // Single byte write
    wdata[0] = 8'h5A;
    do_write("wr10", 8'h10, 1, 1'b1);
    check("wr10 explicit", 32'(we_log.size() > 0 ? we_log[0] : 16'h0), 32'h105A);

    // Random read of that byte
    do_read("rd10", 1'b1, 8'h10, 1);
    check("rd10 explicit", 32'(rdata[0]), 32'h5A);

    // Sequential read across the top of the array
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    do_read("seqFE", 1'b1, 8'hFE, 3);
    check("seqFE b0", 32'(rdata[0]), 32'h11);
    check("seqFE b1", 32'(rdata[1]), 32'h22);
    check("seqFE b2", 32'(rdata[2]), 32'h33);

    // Page write wraps within the 8-byte page
    wdata[0] = 8'hAA; wdata[1] = 8'hBB; wdata[2] = 8'hCC;
    do_write("page06", 8'h06, 3, 1'b1);
    check("page06 third addr", 32'(we_log.size() > 2 ? we_log[2][15:8] : 8'hFF), 32'h00);

    // Foreign device address: no ACK, no write
    we_log.delete();
    start_c();
    write_byte(8'hB0, ack);
    check("devB0 nack", 32'(ack), 32'd1);
    check("devB0 idle", 32'(busy), 32'd0);
    send_bit(1'b0); send_bit(1'b1);
    stop_c();
    check("devB0 no we", 32'(we_log.size()), 32'd0);

    // STOP in the middle of a data byte
    we_log.delete();
    start_c();
    write_byte(8'hA0, ack); check("abort dev ack", 32'(ack), 32'd0);
    write_byte(8'h40, ack); check("abort word ack", 32'(ack), 32'd0);
    ref_addr = 8'h40;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    stop_c();
    check("abort idle",  32'(busy), 32'd0);
    check("abort no we", 32'(we_log.size()), 32'd0);
    check("abort addr",  32'(mem_addr), 32'h40);

    // Reset during a read
    start_c();
    write_byte(8'hA1, ack); check("rstrd dev ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(HALF); scl_in = 1'b1; tick(HALF); scl_in = 1'b0; tick(2);
    end
    check("rstrd busy before", 32'(busy), 32'd1);
    rst_n = 1'b0; tick(2);
    check("rstrd sda_out", 32'(sda_out), 32'd1);
    check("rstrd busy",    32'(busy),    32'd0);
    check("rstrd addr",    32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    ref_addr = 0;
    sda_in = 1'b1; tick(2);
    scl_in = 1'b1; tick(HALF);

`ifdef I2C_EEPROM_WP_EN
    // Protected write: acknowledged, address advances, nothing stored
    wp = 1'b1;
    wdata[0] = 8'h77;
    do_write("wp20", 8'h20, 1, 1'b0);
    wp = 1'b0;
    check("wp20 addr advanced", 32'(mem_addr), 32'h21);
    do_read("wp21", 1'b0, 8'h00, 1);
`endif

    // Randomized write/read-back traffic
    for (int it = 0; it < 6; it++) begin
      a = 8'($urandom);
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
      do_write($sformatf("rw%0d", it), a, n, 1'b1);
      do_read($sformatf("rb%0d", it), 1'b1, a, n);
      do_read($sformatf("rc%0d", it), 1'b0, 8'h00, int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
